// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared types and constants for the write-back stage
//
// Purpose : write-back source encoding, default widths, the elastic-buffer
//           state enum and the packed entry type carried through the stage.
// Ports   : none (package).
package riscv_wb_pkg;

    localparam int WB_XLEN       = 32;
    localparam int WB_REG_ADDR_W = 5;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_buf_state_e;

    typedef struct packed {
        logic [WB_XLEN-1:0]       alu_result;
        logic [WB_XLEN-1:0]       mem_rdata;
        logic [WB_XLEN-1:0]       pc_plus4;
        logic [WB_XLEN-1:0]       imm;
        logic [1:0]               wb_sel;
        logic [WB_REG_ADDR_W-1:0] rd;
        logic                     reg_write;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - 4:1 write-back result selector
//
// Purpose : picks the write-back value from the four result sources using
//           the WB_SEL encoding. Purely combinational.
// Ports   : sel_i       - source select (WB_SEL_*)
//           alu_i       - ALU result
//           mem_i       - load data
//           pc4_i       - return address
//           imm_i       - immediate
//           result_o    - selected value, full XLEN width, no extension
module wb_result_mux
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [1:0]      sel_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [XLEN-1:0] mem_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = alu_i;
        case (sel_i)
            WB_SEL_ALU: result_o = alu_i;
            WB_SEL_MEM: result_o = mem_i;
            WB_SEL_PC4: result_o = pc4_i;
            WB_SEL_IMM: result_o = imm_i;
            default:    result_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_buffer.sv
// rtl/wb_stage_buffer.sv - MEM/WB stage with 2-entry elastic buffer
//
// Purpose : buffers completed instructions in a head + skid register pair,
//           selects the write-back value and drives the register-file
//           write port. Optional forwarding outputs under WB_BYPASS_EN.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           in_valid/in_ready - upstream handshake (in_ready registered)
//           in_*              - entry fields: sources, wb_sel, rd, reg_write
//           flush             - drop every buffered entry
//           rf_ready          - register file takes the head entry
//           out_valid         - head entry present
//           rf_we/rf_waddr/rf_wdata - register-file write port
//           fwd_valid/fwd_rd/fwd_data - forwarding copy (WB_BYPASS_EN only)
module wb_stage_buffer
    import riscv_wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_mem_rdata,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [1:0]            in_wb_sel,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  flush,
    input  logic                  rf_ready,
    output logic                  out_valid,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
`ifdef WB_BYPASS_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data
`endif
);

    wb_buf_state_e state_q, state_d;
    wb_entry_t     head_q, head_d;
    wb_entry_t     skid_q, skid_d;
    wb_entry_t     in_entry;

    logic          accept;
    logic          retire;
    logic [XLEN-1:0] head_wdata;

    assign in_entry.alu_result = in_alu_result;
    assign in_entry.mem_rdata  = in_mem_rdata;
    assign in_entry.pc_plus4   = in_pc_plus4;
    assign in_entry.imm        = in_imm;
    assign in_entry.wb_sel     = in_wb_sel;
    assign in_entry.rd         = in_rd;
    assign in_entry.reg_write  = in_reg_write;

    // Both handshake qualifiers come from the state register only, so
    // in_ready never has a combinational path from rf_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);

    assign accept = in_valid & in_ready;
    assign retire = out_valid & rf_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers are left as-is; only occupancy is dropped.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a retire can happen.
                    if (retire) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    wb_result_mux #(
        .XLEN(XLEN)
    ) u_result_mux (
        .sel_i   (head_q.wb_sel),
        .alu_i   (head_q.alu_result),
        .mem_i   (head_q.mem_rdata),
        .pc4_i   (head_q.pc_plus4),
        .imm_i   (head_q.imm),
        .result_o(head_wdata)
    );

    assign rf_waddr = head_q.rd;
    assign rf_wdata = head_wdata;
    // x0 is hardwired to zero; the entry still retires, it just never writes.
    assign rf_we    = out_valid & head_q.reg_write & (head_q.rd != '0);

`ifdef WB_BYPASS_EN
    assign fwd_valid = rf_we;
    assign fwd_rd    = out_valid ? rf_waddr : '0;
    assign fwd_data  = out_valid ? rf_wdata : '0;
`endif

endmodule

// File: doc/wb_stage_buffer.md
Name: wb_stage_buffer

Overview:
- MEM/WB pipeline stage for the RISC-V core.
- Buffers completed instructions in a 2-entry elastic buffer: head register plus skid register.
- Selects the write-back value from four sources and drives the register-file write port.
- Sits directly upstream of the register file. The 4:1 result selection inside this block feeds the register-file write data.

Parameters:
- XLEN, 32, data width of every source and of the write data
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry this cycle
- in_alu_result  in  XLEN  ALU result
- in_mem_rdata  in  XLEN  load data
- in_pc_plus4  in  XLEN  return address
- in_imm  in  XLEN  immediate (LUI)
- in_wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 IMM
- in_rd  in  REG_ADDR_W  destination register
- in_reg_write  in  1  instruction writes rd
- flush  in  1  discard all buffered entries
- rf_ready  in  1  register file accepts the head entry
- out_valid  out  1  head entry present
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  XLEN  selected write data

Behaviour:
- Entry fields: the four sources, wb_sel, rd, reg_write.
- Handshakes:
  - accept = in_valid & in_ready.
  - retire = out_valid & rf_ready.
- in_ready is registered: in_ready = ~skid_valid. It must not combinationally depend on rf_ready.
- States:
  - EMPTY: no entries.
  - ONE: head valid.
  - TWO: head and skid valid.
- Transitions:
  - EMPTY + accept -> ONE; the entry is loaded into head.
  - ONE + accept + retire -> ONE; head is replaced by the new entry.
  - ONE + accept, no retire -> TWO; the new entry is loaded into skid.
  - ONE + retire, no accept -> EMPTY.
  - TWO + retire -> ONE; skid moves to head. No accept is possible in TWO.
  - Otherwise hold.
- Ordering: strict FIFO. Skid data never overtakes head.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 entry per cycle while rf_ready stays high.
- Outputs are combinational from the head register:
  - rf_waddr = head.rd.
  - rf_wdata = source chosen by head.wb_sel.
  - rf_we = out_valid & head.reg_write & (head.rd != 0).
- Entries with reg_write=0 still occupy a slot and retire only on rf_ready.
- rd = 0 is never written; the entry still retires normally.
- No arithmetic; all sources pass through at full XLEN width, with no extension.
- flush:
  - Next state EMPTY and in_ready = 1.
  - Has priority over accept and retire in the same cycle; any entry presented that cycle is dropped.
  - Data registers need not clear.
- rst (synchronous):
  - State EMPTY, out_valid = 0, rf_we = 0, in_ready = 1 on the cycle after.
  - Head and skid data cleared to 0, so rf_waddr = 0 and rf_wdata = 0.
  - rst has priority over flush and over all handshakes.
  - rst asserted mid-burst drops all entries.
- Simultaneous accept and retire in ONE must not lose or duplicate an entry.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined:
  - Adds outputs fwd_valid (1), fwd_rd (REG_ADDR_W) and fwd_data (XLEN) for execute-stage forwarding.
  - fwd_valid = rf_we, fwd_rd = rf_waddr, fwd_data = rf_wdata, all from the head entry.
  - All three are 0 when out_valid = 0.
- When undefined: these ports do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package riscv_wb_pkg:
  - WB_SEL_ALU/MEM/PC4/IMM constants (2-bit).
  - Default XLEN and REG_ADDR_W.
  - Buffer state enum: EMPTY/ONE/TWO.
  - Packed wb_entry struct type.
- One sub-module, wb_result_mux: XLEN-wide 4:1 selector keyed by the WB_SEL encoding, purely combinational, instantiated once on the head entry.

Test Plan:
- Reset, then single entry: alu=0x11, wb_sel=00, rd=5, reg_write=1, rf_ready=1 -> next cycle out_valid=1, rf_we=1, rf_waddr=5, rf_wdata=0x11; EMPTY the cycle after.
- Select coverage: four entries with wb_sel 00/01/10/11 and distinct sources (0xA, 0xB, 0xC, 0xD) streamed with rf_ready=1 -> rf_wdata sequence 0xA, 0xB, 0xC, 0xD on consecutive cycles.
- Backpressure: rf_ready=0, push entries E1 and E2 -> in_ready=0 after E2; a held E3 is not accepted. Raise rf_ready -> retire E1, E2, E3 in order with none lost or duplicated.
- x0 guard: rd=0, reg_write=1, mem_rdata=0xDEADBEEF, wb_sel=01 -> out_valid=1, rf_we=0, entry still retires.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, presented entry dropped. Also: rst asserted while in ONE -> out_valid=0, rf_waddr=0, rf_wdata=0.
- With WB_BYPASS_EN defined: entry rd=7, imm=0x1000, wb_sel=11, rf_ready=0 -> fwd_valid=1, fwd_rd=7, fwd_data=0x1000 held until retire.
